switch_debounce_leds: RTL and testbench

//  N-channel switch-to-LED block. Each channel synchronises a raw push-button input,

---
 rtl/sw_led_pkg.sv | 22 ++
 rtl/switch_debounce_leds_debounce_filter.sv | 63 ++++++
 rtl/switch_debounce_leds.sv | 80 ++++++++
 tb/tb_switch_debounce_leds.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_led_pkg.sv
// ---------------------------------------------------------------------------
// sw_led_pkg
//
// Shared definitions for the switch-to-LED block.
//
// Contents
//   MODE_FOLLOW / MODE_TOGGLE : selectors for the LED drive behaviour
//   clog2_cnt(d)              : width of a hold counter able to count 0..d
// ---------------------------------------------------------------------------
package sw_led_pkg;

  // LED drive behaviour selectors for the top-level MODE parameter
  localparam int MODE_FOLLOW = 0;
  localparam int MODE_TOGGLE = 1;

  // Width of the debounce hold counter. Sized to hold the value d so that
  // d == 1 still yields a legal one-bit counter.
  function automatic int clog2_cnt(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_leds_debounce_filter.sv
// ---------------------------------------------------------------------------
// debounce_filter
//
// Single-channel switch conditioner: a two-flop synchroniser followed by a
// hold counter. The filtered level only changes after the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive cycles a new level must persist (>= 1)
//
// Ports
//   i_Clk    in  1  system clock
//   i_Rst_L  in  1  synchronous active-low reset
//   i_Raw    in  1  raw asynchronous switch pin
//   o_Stable out 1  debounced level (registered)
// ---------------------------------------------------------------------------
module debounce_filter
  import sw_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Stable
);

  localparam int CW = clog2_cnt(DEBOUNCE_CYCLES);

  // Terminal count: reaching it while the input still disagrees commits
  // the new level on the same edge, so the level changes after exactly
  // DEBOUNCE_CYCLES disagreeing samples.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Synchroniser and hold counter. Any agreement between the synchronised
  // input and the current level clears the count, so short bounces are
  // discarded completely rather than accumulated. The counter is cleared
  // on commit and never passes CNT_LAST, so it cannot wrap.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      cnt      <= '0;
      o_Stable <= 1'b0;
    end else begin
      sync_1 <= i_Raw;
      sync_2 <= sync_1;
      if (sync_2 == o_Stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        o_Stable <= sync_2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debounce_leds.sv
// ---------------------------------------------------------------------------
// switch_debounce_leds
//
// N-channel switch-to-LED block. Each channel is debounced independently;
// the LED either follows the debounced level (optionally inverted) or
// toggles once per debounced release. A one-cycle pulse is emitted on every
// debounced release (1 -> 0) for downstream logic.
//
// Parameters
//   N_CH            : number of channels (1..16)
//   DEBOUNCE_CYCLES : consecutive cycles a new level must persist (>= 1)
//   MODE            : MODE_FOLLOW (0) or MODE_TOGGLE (1)
//   INVERT          : FOLLOW only, 1 drives the LED with the inverted level
//
// Ports
//   i_Clk      in  1     system clock, single domain
//   i_Rst_L    in  1     synchronous active-low reset
//   i_Switch   in  N_CH  raw switch pins, active-high, asynchronous
//   o_LED      out N_CH  registered LED drive, active-high
//   o_Release  out N_CH  one-cycle pulse per debounced release
// ---------------------------------------------------------------------------
module switch_debounce_leds
  import sw_led_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MODE            = 1,
  parameter int INVERT          = 0
) (
  input  logic            i_Clk,
  input  logic            i_Rst_L,
  input  logic [N_CH-1:0] i_Switch,
  output logic [N_CH-1:0] o_LED,
  output logic [N_CH-1:0] o_Release
);

  // All-ones when FOLLOW output is inverted; unused in TOGGLE mode.
  localparam logic [N_CH-1:0] INV_MASK = (INVERT != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] stable_d;
  logic [N_CH-1:0] rel;

  // One independent synchroniser/debouncer per channel.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    debounce_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Raw   (i_Switch[k]),
      .o_Stable(stable[k])
    );
  end

  // Falling edge of the debounced level marks a release. stable_d resets
  // to 0 together with stable, so leaving reset can never look like a
  // release even if a switch was held through it.
  assign rel = stable_d & ~stable;

  // Output registers. In TOGGLE mode the LED flips from the registered
  // release pulse, so the flip lands one cycle after o_Release rises and
  // every pulse produces exactly one flip.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      stable_d  <= '0;
      o_Release <= '0;
      o_LED     <= '0;
    end else begin
      stable_d  <= stable;
      o_Release <= rel;
      if (MODE == MODE_TOGGLE) begin
        o_LED <= o_LED ^ o_Release;
      end else begin
        o_LED <= stable ^ INV_MASK;
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce_leds.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce_leds
//
// Drives three copies of the design (TOGGLE, FOLLOW, FOLLOW+INVERT) from the
// same switch/reset stimulus and compares every output each cycle against a
// behavioural model. The model states the debounce rule as a sliding window:
// the debounced bit flips once the last DEBOUNCE_CYCLES synchronised samples
// all disagree with it, the synchroniser contributing two cycles of delay.
// ---------------------------------------------------------------------------
module tb_switch_debounce_leds;

  localparam int N = 4;
  localparam int D = 4;

  logic         i_Clk = 1'b0;
  logic         i_Rst_L = 1'b0;
  logic [N-1:0] i_Switch = '0;

  logic [N-1:0] led_t, rel_t, led_f, rel_f, led_i, rel_i;

  int total = 0;
  int bad = 0;

  // Model state: raw samples per edge (oldest first), debounced level after
  // the last edge and the one before, expected registered outputs.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_st1, m_st2, m_rel, m_led_t, m_led_f, m_led_i;

  always #5 i_Clk = ~i_Clk;

  switch_debounce_leds #(.N_CH(N), .DEBOUNCE_CYCLES(D), .MODE(1), .INVERT(0)) u_toggle (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch), .o_LED(led_t), .o_Release(rel_t));

  switch_debounce_leds #(.N_CH(N), .DEBOUNCE_CYCLES(D), .MODE(0), .INVERT(0)) u_follow (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch), .o_LED(led_f), .o_Release(rel_f));

  switch_debounce_leds #(.N_CH(N), .DEBOUNCE_CYCLES(D), .MODE(0), .INVERT(1)) u_follow_inv (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch), .o_LED(led_i), .o_Release(rel_i));

  // Advance the model by one rising edge using the inputs seen on that edge.
  task automatic model_step(input logic rst_n, input logic [N-1:0] sw);
    logic [N-1:0] nst;
    logic         all_diff;
    if (!rst_n) begin
      hist.delete();
      for (int j = 0; j <= D; j++) hist.push_back('0);
      m_st1 = '0; m_st2 = '0; m_rel = '0;
      m_led_t = '0; m_led_f = '0; m_led_i = '0;
    end else begin
      nst = m_st1;
      for (int b = 0; b < N; b++) begin
        all_diff = 1'b1;
        // samples from two edges ago back to D+1 edges ago
        for (int j = 1; j <= D; j++)
          if (hist[hist.size() - 1 - j][b] == m_st1[b]) all_diff = 1'b0;
        if (all_diff) nst[b] = ~m_st1[b];
      end
      m_led_t = m_led_t ^ m_rel;
      m_rel   = m_st2 & ~m_st1;
      m_led_f = m_st1;
      m_led_i = ~m_st1;
      m_st2   = m_st1;
      m_st1   = nst;
      hist.push_back(sw);
      while (hist.size() > D + 1) void'(hist.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    model_step(i_Rst_L, i_Switch);
    #1;
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0;
    i_Switch = 4'hF;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== 24'h0) begin
        bad++;
        $display("[TB] FAIL reset_hold c=%0d: got led t/f/i=%h/%h/%h rel=%h/%h/%h required all 0",
                 c, led_t, led_f, led_i, rel_t, rel_f, rel_i);
      end
    end
    i_Rst_L = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}) begin
        bad++;
        $display("[TB] FAIL reset_model e=%0d: got led t/f/i=%h/%h/%h rel=%h/%h/%h required %h/%h/%h rel=%h",
                 e, led_t, led_f, led_i, rel_t, rel_f, rel_i, m_led_t, m_led_f, m_led_i, m_rel);
      end
      if (e >= 6) begin
        total++;
        if (led_f !== ((e == 7) ? 4'hF : 4'h0)) begin
          bad++;
          $display("[TB] FAIL reset_follow_latency e=%0d: got %h required %h", e, led_f, (e == 7) ? 4'hF : 4'h0);
        end
      end
    end
  endtask

  task automatic test_bounce();
    i_Rst_L = 1'b0;
    i_Switch = '0;
    tick();
    i_Rst_L = 1'b1;
    for (int c = 0; c < 20; c++) begin
      i_Switch[0] = ~c[1];
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}
          || led_f[0] !== 1'b0 || rel_f[0] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bounce c=%0d: got led t/f/i=%h/%h/%h rel=%h/%h/%h required %h/%h/%h rel=%h",
                 c, led_t, led_f, led_i, rel_t, rel_f, rel_i, m_led_t, m_led_f, m_led_i, m_rel);
      end
    end
    i_Switch[0] = 1'b1;
    for (int h = 1; h <= 7; h++) begin
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}
          || led_f[0] !== (h == 7) || rel_f[0] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bounce_hold h=%0d: got led_f=%h rel_f=%h required led_f[0]=%0d rel_f[0]=0",
                 h, led_f, rel_f, (h == 7));
      end
    end
  endtask

  task automatic test_toggle();
    logic [N-1:0] want_led;
    i_Rst_L = 1'b0;
    i_Switch = '0;
    tick();
    i_Rst_L = 1'b1;
    repeat (8) tick();
    for (int rep = 0; rep < 2; rep++) begin
      i_Switch = 4'h4;
      for (int c = 0; c < 10; c++) begin
        tick();
        total++;
        if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}) begin
          bad++;
          $display("[TB] FAIL toggle_press rep=%0d c=%0d: got led_t=%h rel_t=%h required %h/%h",
                   rep, c, led_t, rel_t, m_led_t, m_rel);
        end
      end
      i_Switch = 4'h0;
      want_led = (rep == 0) ? 4'h4 : 4'h0;
      for (int e = 1; e <= 9; e++) begin
        tick();
        total++;
        if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}
            || rel_t !== ((e == 7) ? 4'h4 : 4'h0)
            || (e >= 8 && led_t !== want_led) || (e < 8 && led_t !== (want_led ^ 4'h4))) begin
          bad++;
          $display("[TB] FAIL toggle_release rep=%0d e=%0d: got led_t=%h rel_t=%h required led_t=%h rel_t=%h",
                   rep, e, led_t, rel_t, (e >= 8) ? want_led : (want_led ^ 4'h4), (e == 7) ? 4'h4 : 4'h0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    i_Switch = 4'h9;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}) begin
        bad++;
        $display("[TB] FAIL simul_press c=%0d: got led t/f=%h/%h rel_t=%h required %h/%h/%h",
                 c, led_t, led_f, rel_t, m_led_t, m_led_f, m_rel);
      end
    end
    i_Switch = 4'h0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}
          || rel_t !== ((e == 7) ? 4'h9 : 4'h0) || led_t !== ((e >= 8) ? 4'h9 : 4'h0)) begin
        bad++;
        $display("[TB] FAIL simul_release e=%0d: got led_t=%h rel_t=%h required led_t=%h rel_t=%h",
                 e, led_t, rel_t, (e >= 8) ? 4'h9 : 4'h0, (e == 7) ? 4'h9 : 4'h0);
      end
    end
  endtask

  task automatic test_invert();
    i_Rst_L = 1'b0;
    i_Switch = 4'h5;
    tick();
    i_Rst_L = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}
          || (e == 7 && led_i !== 4'hA) || (e == 1 && led_i !== 4'hF)) begin
        bad++;
        $display("[TB] FAIL invert_settle e=%0d: got led_i=%h required %h", e, led_i, m_led_i);
      end
    end
    for (int c = 0; c < 15; c++) begin
      i_Switch = (c < 3) ? 4'h7 : 4'h5;
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}
          || led_i !== 4'hA) begin
        bad++;
        $display("[TB] FAIL invert_glitch c=%0d: got led_i=%h rel_i=%h required led_i=a rel_i=%h",
                 c, led_i, rel_i, m_rel);
      end
    end
  endtask

  task automatic test_reset_mid();
    i_Rst_L = 1'b0;
    i_Switch = '0;
    tick();
    i_Rst_L = 1'b1;
    i_Switch = 4'h2;
    repeat (8) tick();
    total++;
    if (led_f !== 4'h2) begin
      bad++;
      $display("[TB] FAIL midrst_setup: got led_f=%h required 2", led_f);
    end
    // release ch1 long enough to be part-way through its count
    i_Switch = 4'h0;
    repeat (4) tick();
    total++;
    if (led_f !== 4'h2 || rel_f !== 4'h0) begin
      bad++;
      $display("[TB] FAIL midrst_counting: got led_f=%h rel_f=%h required 2/0", led_f, rel_f);
    end
    i_Rst_L = 1'b0;
    i_Switch = 4'h2;
    tick();
    total++;
    if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== 24'h0) begin
      bad++;
      $display("[TB] FAIL midrst_clear: got led t/f/i=%h/%h/%h rel=%h/%h/%h required all 0",
               led_t, led_f, led_i, rel_t, rel_f, rel_i);
    end
    i_Rst_L = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      total++;
      if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}
          || (rel_t | rel_f | rel_i) !== 4'h0 || led_f !== ((e == 7) ? 4'h2 : 4'h0)) begin
        bad++;
        $display("[TB] FAIL midrst_redebounce e=%0d: got led_f=%h rel_f=%h required led_f=%h rel_f=0",
                 e, led_f, rel_f, (e == 7) ? 4'h2 : 4'h0);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      i_Rst_L  = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      i_Switch = 4'($urandom_range(0, 15));
      hold     = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        tick();
        i_Rst_L = 1'b1;
        total++;
        if ({led_t, led_f, led_i, rel_t, rel_f, rel_i} !== {m_led_t, m_led_f, m_led_i, m_rel, m_rel, m_rel}) begin
          bad++;
          $display("[TB] FAIL random seg=%0d h=%0d: got led t/f/i=%h/%h/%h rel=%h/%h/%h required %h/%h/%h rel=%h",
                   seg, h, led_t, led_f, led_i, rel_t, rel_f, rel_i, m_led_t, m_led_f, m_led_i, m_rel);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_toggle();
    test_back_to_back();
    test_invert();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
